// File: rtl/ama_err_monitor.sv
// Observer for an approximate adder: recomputes the exact sum and gathers error
// statistics (error count, max and saturating sum of |exact - appr|) over a window.
module ama_err_monitor #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] s_appr,
  input  logic             cout_appr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   max_ed,
  output logic [ACC_W-1:0] sum_ed
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] win_len_q;
  logic             acc_p0;
  logic             clr;
  logic [WIDTH:0]   exact_p0, appr_p0;
  logic [WIDTH:0]   exact_p1, appr_p1;
  logic             vld_p1;
  logic [WIDTH:0]   ed_p1;

  function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH:0] x,
                                              input logic [WIDTH:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [WIDTH:0]   inc);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W-WIDTH){1'b0}}, inc};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  always_comb begin
    state_nxt = state;
    acc_p0    = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = (win_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (in_valid) begin
          acc_p0 = 1'b1;
          if (sample_cnt + CNT_W'(1) == win_len_q) state_nxt = DRAIN;
        end
      end
      // The last sample sits in stage 1 and retires into the statistics on this
      // edge, so both stages are empty once DONE is reached.
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      vld_p1    <= 1'b0;
      win_len_q <= '0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done   <= (state_nxt == DONE);
      vld_p1 <= acc_p0;
      if (clr) win_len_q <= win_len;
    end
  end

  // ---- stage 0 -> 1: exact sum and approximate result of an accepted sample
  assign exact_p0 = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign appr_p0  = {cout_appr, s_appr};

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      exact_p1 <= exact_p0;
      appr_p1  <= appr_p0;
    end
  end

  // ---- stage 1 -> 2: error distance folded into the statistics
  assign ed_p1 = abs_diff(exact_p1, appr_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
    end else if (clr) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
    end else begin
      if (acc_p0) sample_cnt <= sample_cnt + CNT_W'(1);
      if (vld_p1) begin
        if (ed_p1 != '0)    err_cnt <= err_cnt + CNT_W'(1);
        if (ed_p1 > max_ed) max_ed  <= ed_p1;
        sum_ed <= sat_add(sum_ed, ed_p1);
      end
    end
  end

endmodule

// File: tb/tb_ama_err_monitor.sv
// Self-checking bench for ama_err_monitor: directed scenarios plus random traffic
// against a timestamp-based model, on a 40-bit and a 26-bit accumulator instance.
module tb_ama_err_monitor;
  localparam int W  = 24;
  localparam int CW = 16;
  localparam longint MAX40 = (64'd1 << 40) - 1;
  localparam longint MAX26 = (64'd1 << 26) - 1;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic          cin = 1'b0, cout_appr = 1'b0;
  logic [CW-1:0] win_len = '0;
  logic [W-1:0]  a = '0, b = '0, s_appr = '0;

  logic          busy, done, busy26, done26;
  logic [CW-1:0] scnt, ecnt, scnt26, ecnt26;
  logic [W:0]    maxed, maxed26;
  logic [39:0]   sum40;
  logic [25:0]   sum26;

  always #5 clk = ~clk;

  ama_err_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .s_appr(s_appr), .cout_appr(cout_appr),
    .busy(busy), .done(done), .sample_cnt(scnt), .err_cnt(ecnt),
    .max_ed(maxed), .sum_ed(sum40));

  ama_err_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(26)) dut26 (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .s_appr(s_appr), .cout_appr(cout_appr),
    .busy(busy26), .done(done26), .sample_cnt(scnt26), .err_cnt(ecnt26),
    .max_ed(maxed26), .sum_ed(sum26));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
  endtask

  // Model: every accepted sample is kept with the edge index that accepted it.
  // Outputs after edge e: sample_cnt counts samples accepted up to e, statistics
  // cover samples accepted up to e-1, done is high only after edge done_at.
  int     e_cnt = 0;
  bit     m_open = 1'b0;
  int     m_target = 0;
  int     done_at = -10;
  int     busy_until = -10;
  longint q_ed[$];
  int     q_edge[$];

  initial begin : model
    longint ex, ap, ed;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_open = 1'b0; done_at = -10; busy_until = -10;
        q_ed.delete(); q_edge.delete();
      end else begin
        e_cnt++;
        if (start && !m_open && e_cnt >= done_at + 2) begin
          q_ed.delete(); q_edge.delete();
          if (win_len != '0) begin
            m_open = 1'b1;
            m_target = int'(win_len);
          end else begin
            done_at = e_cnt;
          end
        end else if (m_open && in_valid) begin
          ex = longint'(a) + longint'(b) + longint'(cin);
          ap = (longint'(cout_appr) << W) + longint'(s_appr);
          ed = (ex > ap) ? ex - ap : ap - ex;
          q_ed.push_back(ed);
          q_edge.push_back(e_cnt);
          if (q_ed.size() == m_target) begin
            m_open = 1'b0;
            busy_until = e_cnt;
            done_at = e_cnt + 1;
          end
        end
      end
    end
  end

  initial begin : compare
    longint s40, s26, mx;
    int     ec;
    bit     busy_e, done_e;
    forever begin
      @(negedge clk);
      s40 = 0; s26 = 0; mx = 0; ec = 0;
      foreach (q_ed[i]) begin
        if (q_edge[i] <= e_cnt - 1) begin
          if (q_ed[i] != 0) ec++;
          if (q_ed[i] > mx) mx = q_ed[i];
          s40 = (s40 + q_ed[i] > MAX40) ? MAX40 : s40 + q_ed[i];
          s26 = (s26 + q_ed[i] > MAX26) ? MAX26 : s26 + q_ed[i];
        end
      end
      busy_e = m_open || (e_cnt <= busy_until);
      done_e = (e_cnt == done_at);
      chk("busy", busy, busy_e);
      chk("done", done, done_e);
      chk("sample_cnt", scnt, q_ed.size());
      chk("err_cnt", ecnt, ec);
      chk("max_ed", maxed, mx);
      chk("sum_ed", sum40, s40);
      chk("busy26", busy26, busy_e);
      chk("done26", done26, done_e);
      chk("sample_cnt26", scnt26, q_ed.size());
      chk("err_cnt26", ecnt26, ec);
      chk("max_ed26", maxed26, mx);
      chk("sum_ed26", sum26, s26);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int len);
    start = 1'b1;
    win_len = CW'(len);
    cyc();
    start = 1'b0;
  endtask

  task automatic smp(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                     input logic [W-1:0] is, input logic ico);
    a = ia; b = ib; cin = ic; s_appr = is; cout_appr = ico; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic smp_ex(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    logic [W:0] ex;
    ex = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    smp(ia, ib, ic, ex[W-1:0], ex[W]);
  endtask

  task automatic wait_done(input int bound, output int waited);
    waited = 0;
    while (done !== 1'b1 && waited < bound) begin
      cyc();
      waited++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin : stim
    int w;
    logic [W:0] ex;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", scnt, 0);
    chk("rst_sum", sum40, 0);

    // reset in the middle of a window
    go(8);
    repeat (3) smp(24'h10, 24'h01, 1'b0, 24'h0F, 1'b0);
    chk("mid_cnt", scnt, 3);
    chk("mid_err", ecnt, 2);
    rst_n = 1'b0;
    cyc();
    chk("abort_busy", busy, 0);
    chk("abort_cnt", scnt, 0);
    chk("abort_err", ecnt, 0);
    chk("abort_sum", sum40, 0);
    rst_n = 1'b1;
    go(2);
    smp_ex(24'h000123, 24'h000456, 1'b0);
    smp_ex(24'hABCDEF, 24'h987654, 1'b1);
    wait_done(5, w);
    chk("after_abort_cnt", scnt, 2);
    cyc();

    // exact window, done latency
    go(4);
    smp_ex(24'h000010, 24'h000001, 1'b0);
    smp_ex(24'h7FFFFF, 24'h000001, 1'b0);
    smp_ex(24'hFFFFFF, 24'hFFFFFF, 1'b1);
    smp_ex(24'h0F0F0F, 24'hF0F0F0, 1'b0);
    chk("exact_busy_drain", busy, 1);
    chk("exact_done_early", done, 0);
    cyc();
    chk("exact_done", done, 1);
    chk("exact_busy", busy, 0);
    chk("exact_cnt", scnt, 4);
    chk("exact_err", ecnt, 0);
    chk("exact_max", maxed, 0);
    chk("exact_sum", sum40, 0);
    cyc();
    chk("exact_done_pulse", done, 0);

    // mixed errors: ED 2, 2, 0
    go(3);
    smp(24'h000010, 24'h000001, 1'b0, 24'h00000F, 1'b0);
    smp(24'h00003F, 24'h000001, 1'b1, 24'h00003F, 1'b0);
    smp(24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1);
    wait_done(5, w);
    chk("mixed_lat", w, 1);
    chk("mixed_err", ecnt, 2);
    chk("mixed_max", maxed, 2);
    chk("mixed_sum", sum40, 4);
    chk("mixed_sum26", sum26, 4);
    cyc();

    // gapped input, start ignored in RUN, sample in DRAIN ignored
    go(2);
    smp(24'h000010, 24'h000001, 1'b0, 24'h00000F, 1'b0);
    start = 1'b1; win_len = 16'd5;
    cyc();
    start = 1'b0;
    chk("gap_busy", busy, 1);
    chk("gap_cnt1", scnt, 1);
    cyc();
    smp_ex(24'h00ABCD, 24'h001234, 1'b1);
    chk("gap_busy_drain", busy, 1);
    smp(24'h000000, 24'h000000, 1'b0, 24'h123456, 1'b1);
    chk("gap_done", done, 1);
    chk("gap_cnt", scnt, 2);
    chk("gap_err", ecnt, 1);
    chk("gap_max", maxed, 2);
    chk("gap_sum", sum40, 2);
    cyc();

    // zero-length window
    go(0);
    chk("zl_done", done, 1);
    chk("zl_busy", busy, 0);
    chk("zl_cnt", scnt, 0);
    chk("zl_max", maxed, 0);
    chk("zl_sum", sum40, 0);
    cyc();
    chk("zl_done_pulse", done, 0);

    // saturation on the 26-bit accumulator
    go(4);
    repeat (4) smp(24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'h000000, 1'b0);
    chk("sat_after3_26", sum26, 26'h3FFFFFF);
    chk("sat_after3_40", sum40, 40'h005FFFFFD);
    cyc();
    chk("sat_done", done, 1);
    chk("sat_sum26", sum26, 26'h3FFFFFF);
    chk("sat_sum40", sum40, 40'h007FFFFFC);
    chk("sat_max", maxed26, 25'h1FFFFFF);
    chk("sat_err", ecnt26, 4);
    cyc();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      start    = ($urandom_range(0, 5) == 0);
      win_len  = CW'($urandom_range(0, 10));
      in_valid = ($urandom_range(0, 2) != 0);
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      ex  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      case ($urandom_range(0, 2))
        0: begin s_appr = ex[W-1:0]; cout_appr = ex[W]; end
        1: begin s_appr = ex[W-1:0] ^ {18'b0, 6'($urandom)}; cout_appr = ex[W]; end
        default: begin s_appr = W'($urandom); cout_appr = 1'($urandom); end
      endcase
      cyc();
    end
    start = 1'b0;
    in_valid = 1'b0;
    repeat (30) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
